// File: rtl/alu_sequencer_if.sv
// ============================================================================
// Module : alu_sequencer_if
// Brief  : Instruction handshake and ALU/register-file control bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface alu_sequencer_if #(
  parameter int WIDTH   = 16,
  parameter int NUMREGS = 16
);
  localparam int AW = $clog2(NUMREGS);

  logic             instrValid;
  logic [WIDTH-1:0] instrIn;
  logic             instrReady;
  logic [4:0]       aluConds;
  logic [7:0]       aluOp;
  logic [AW-1:0]    srcAddr;
  logic [AW-1:0]    dstAddr;
  logic [WIDTH-1:0] immOut;
  logic             immSel;
  logic             writeEn;
  logic [4:0]       psr;
  logic             done;
  logic             illegal;

  // Instruction source / datapath side
  modport master (
    output instrValid, instrIn, aluConds,
    input  instrReady, aluOp, srcAddr, dstAddr, immOut, immSel,
           writeEn, psr, done, illegal
  );

  // Sequencer side
  modport slave (
    input  instrValid, instrIn, aluConds,
    output instrReady, aluOp, srcAddr, dstAddr, immOut, immSel,
           writeEn, psr, done, illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module : alu_sequencer
// Brief  : Four-state instruction sequencer driving ALU and register-file control.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_sequencer #(
  parameter int WIDTH   = 16,
  parameter int NUMREGS = 16
) (
  input  wire               clk,
  input  wire               reset,
  alu_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t r_state;
  logic   r_legal;
  logic   r_noWrite;

  logic [3:0]       w_opcode;
  logic [3:0]       w_ext;
  logic [7:0]       w_imm;
  logic [7:0]       w_aluOp;
  logic             w_immSel;
  logic [WIDTH-1:0] w_immOut;
  logic             w_legal;
  logic             w_noWrite;

  assign w_opcode = bus.instrIn[15:12];
  assign w_ext    = bus.instrIn[7:4];
  assign w_imm    = bus.instrIn[7:0];

  // Decode straight from the input word so the control outputs are already
  // registered and stable for the whole DECODE state.
  always_comb begin
    w_aluOp   = 8'h00;
    w_immSel  = 1'b0;
    w_immOut  = '0;
    w_legal   = 1'b0;
    w_noWrite = 1'b0;
    case (w_opcode)
      4'b0000: begin
        w_aluOp   = {w_ext, 4'b0000};
        w_noWrite = (w_ext == 4'b1011);
        case (w_ext)
          4'b0001, 4'b0010, 4'b0011, 4'b0101,
          4'b0110, 4'b1001, 4'b1011: w_legal = 1'b1;
          default:                   w_legal = 1'b0;
        endcase
      end
      4'b1000: begin
        w_aluOp = {4'b1000, w_ext};
        case (w_ext)
          4'b0000, 4'b0010, 4'b1000, 4'b0111: w_legal = 1'b1;
          default:                            w_legal = 1'b0;
        endcase
      end
      4'b0001, 4'b0010, 4'b0011: begin
        w_aluOp  = {w_opcode, 4'b0000};
        w_immSel = 1'b1;
        w_immOut = {{(WIDTH-8){1'b0}}, w_imm};
        w_legal  = 1'b1;
      end
      4'b0101, 4'b0110, 4'b1001, 4'b1011: begin
        w_aluOp   = {w_opcode, 4'b0000};
        w_immSel  = 1'b1;
        w_immOut  = {{(WIDTH-8){w_imm[7]}}, w_imm};
        w_legal   = 1'b1;
        w_noWrite = (w_opcode == 4'b1011);
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_legal        <= 1'b0;
      r_noWrite      <= 1'b0;
      bus.instrReady <= 1'b1;
      bus.writeEn    <= 1'b0;
      bus.done       <= 1'b0;
      bus.illegal    <= 1'b0;
      bus.psr        <= 5'b0;
      bus.aluOp      <= 8'h00;
      bus.srcAddr    <= '0;
      bus.dstAddr    <= '0;
      bus.immSel     <= 1'b0;
      bus.immOut     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.instrValid) begin
            r_state        <= DECODE;
            bus.instrReady <= 1'b0;
            bus.dstAddr    <= bus.instrIn[11:8];
            bus.srcAddr    <= bus.instrIn[3:0];
            bus.aluOp      <= w_aluOp;
            bus.immSel     <= w_immSel;
            bus.immOut     <= w_immOut;
            r_legal        <= w_legal;
            r_noWrite      <= w_noWrite;
          end
        end
        DECODE: r_state <= EXEC;
        EXEC: begin
          r_state     <= WB;
          if (r_legal) begin
            bus.psr <= bus.aluConds;
          end
          bus.writeEn <= r_legal && !r_noWrite;
          bus.done    <= 1'b1;
          bus.illegal <= !r_legal;
        end
        WB: begin
          r_state        <= IDLE;
          bus.writeEn    <= 1'b0;
          bus.done       <= 1'b0;
          bus.illegal    <= 1'b0;
          bus.instrReady <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module : tb_alu_sequencer
// Brief  : Directed scoreboard bench for alu_sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  typedef struct packed {
    logic        chkDec;
    logic [7:0]  aluOp;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic        immSel;
    logic [15:0] immOut;
    logic        writeEn;
    logic        illegal;
    logic [4:0]  psr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_sequencer_if #(.WIDTH(16), .NUMREGS(16)) bus ();

  alu_sequencer #(.WIDTH(16), .NUMREGS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic chkDec, input logic [7:0] op, input logic [3:0] dst,
                              input logic [3:0] src, input logic isel, input logic [15:0] imm,
                              input logic we, input logic ill, input logic [4:0] psr);
    exp_t e;
    e.chkDec = chkDec; e.aluOp = op; e.dst = dst; e.src = src; e.immSel = isel;
    e.immOut = imm; e.writeEn = we; e.illegal = ill; e.psr = psr;
    return e;
  endfunction

  // Starting in cycle 1 after a handshake, walk until done (bounded).
  task automatic collect(output int n);
    n = 1;
    while (bus.done !== 1'b1 && n < 8) begin
      check("we_outside_wb", bus.writeEn, 0);
      check("ill_outside_wb", bus.illegal, 0);
      tick();
      n++;
    end
  endtask

  task automatic finishInstr(input int n);
    exp_t e;
    check("done_seen", bus.done, 1);
    check("latency", n, 3);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("writeEn", bus.writeEn, e.writeEn);
      check("illegal", bus.illegal, e.illegal);
      check("psr", bus.psr, e.psr);
      if (e.chkDec) begin
        check("aluOp", bus.aluOp, e.aluOp);
        check("srcAddr", bus.srcAddr, e.src);
        check("dstAddr", bus.dstAddr, e.dst);
        check("immSel", bus.immSel, e.immSel);
        if (e.immSel) check("immOut", bus.immOut, e.immOut);
      end
    end else begin
      check("sb_nonempty", 0, 1);
    end
    tick();
    check("done_drop", bus.done, 0);
    check("we_drop", bus.writeEn, 0);
    check("ready_back", bus.instrReady, 1);
  endtask

  task automatic send(input logic [15:0] ins, input logic [4:0] conds, input exp_t e);
    int n;
    int w;
    sb.push_back(e);
    w = 0;
    while (bus.instrReady !== 1'b1 && w < 8) begin
      tick();
      w++;
    end
    check("ready_wait", bus.instrReady, 1);
    bus.aluConds   = conds;
    bus.instrValid = 1'b1;
    bus.instrIn    = ins;
    tick();
    bus.instrValid = 1'b0;
    bus.instrIn    = 16'(($urandom & 32'hFFFF));
    check("ready_low", bus.instrReady, 0);
    collect(n);
    finishInstr(n);
  endtask

  initial begin
    int n;
    bus.instrValid = 1'b0;
    bus.instrIn    = 16'h0000;
    bus.aluConds   = 5'b0;
    reset = 1'b0;
    tick();
    tick();
    check("rst_ready", bus.instrReady, 1);
    check("rst_we", bus.writeEn, 0);
    check("rst_done", bus.done, 0);
    check("rst_ill", bus.illegal, 0);
    check("rst_psr", bus.psr, 0);
    check("rst_aluOp", bus.aluOp, 0);
    check("rst_addr", {bus.srcAddr, bus.dstAddr}, 0);
    check("rst_imm", {bus.immSel, bus.immOut}, 0);
    reset = 1'b1;
    tick();

    send(16'h0355, 5'b00000, mk(1, 8'h50, 4'h3, 4'h5, 0, 16'h0000, 1, 0, 5'b00000));
    send(16'h52FF, 5'b00011, mk(1, 8'h50, 4'h2, 4'hF, 1, 16'hFFFF, 1, 0, 5'b00011));
    send(16'h12FF, 5'b10000, mk(1, 8'h10, 4'h2, 4'hF, 1, 16'h00FF, 1, 0, 5'b10000));
    send(16'h01B1, 5'b00100, mk(1, 8'hB0, 4'h1, 4'h1, 0, 16'h0000, 0, 0, 5'b00100));
    send(16'hF000, 5'b11111, mk(0, 8'h00, 4'h0, 4'h0, 0, 16'h0000, 0, 1, 5'b00100));
    send(16'h8372, 5'b00001, mk(1, 8'h87, 4'h3, 4'h2, 0, 16'h0000, 1, 0, 5'b00001));
    send(16'h0040, 5'b11110, mk(0, 8'h00, 4'h0, 4'h0, 0, 16'h0000, 0, 1, 5'b00001));
    send(16'hB4F0, 5'b01000, mk(1, 8'hB0, 4'h4, 4'h0, 1, 16'hFFF0, 0, 0, 5'b01000));
    send(16'h2480, 5'b00010, mk(1, 8'h20, 4'h4, 4'h0, 1, 16'h0080, 1, 0, 5'b00010));

    // Back-to-back with instrValid held high
    sb.push_back(mk(1, 8'h50, 4'h3, 4'h5, 0, 16'h0000, 1, 0, 5'b00110));
    sb.push_back(mk(1, 8'h20, 4'h1, 4'h3, 0, 16'h0000, 1, 0, 5'b00110));
    bus.aluConds   = 5'b00110;
    bus.instrValid = 1'b1;
    bus.instrIn    = 16'h0355;
    tick();
    bus.instrIn = 16'h0123;
    for (int c = 1; c <= 3; c++) begin
      check("b2b_ready_low", bus.instrReady, 0);
      if (c < 3) tick();
    end
    finishInstr(3);
    tick();
    check("b2b_second_accept", bus.instrReady, 0);
    bus.instrValid = 1'b0;
    collect(n);
    finishInstr(n);

    // Reset while in EXEC aborts the instruction
    bus.aluConds   = 5'b10101;
    bus.instrValid = 1'b1;
    bus.instrIn    = 16'h0355;
    tick();
    bus.instrValid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_ready", bus.instrReady, 1);
    check("abort_we", bus.writeEn, 0);
    check("abort_done", bus.done, 0);
    check("abort_psr", bus.psr, 0);
    check("abort_aluOp", bus.aluOp, 0);
    check("abort_addr", {bus.srcAddr, bus.dstAddr}, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("abort_no_we", {bus.writeEn, bus.done}, 0);
    end

    // Reset dominates a simultaneous handshake
    reset = 1'b0;
    bus.instrValid = 1'b1;
    tick();
    reset = 1'b1;
    bus.instrValid = 1'b0;
    tick();
    check("rst_dominates", bus.instrReady, 1);

    send(16'h0355, 5'b00000, mk(1, 8'h50, 4'h3, 4'h5, 0, 16'h0000, 1, 0, 5'b00000));
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, 16, datapath and instruction width.
REQ-002 Parameter: NUMREGS, 16, register-file depth; address width $clog2(NUMREGS) = 4.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 instrValid  input  1  instrIn holds a valid instruction.
REQ-006 instrIn  input  16  instruction: [15:12] opcode, [11:8] Rdest, [7:4] opext/imm[7:4], [3:0] Rsrc/imm[3:0].
REQ-007 instrReady  output  1  sequencer can accept an instruction.
REQ-008 aluConds  input  5  ALU flags {cond_group2[2:0], cond_group1}, valid in EXEC.
REQ-009 aluOp  output  8  ALU operation select.
REQ-010 srcAddr, dstAddr  output  4 each  register-file read/write addresses.
REQ-011 immOut  output  16  extended immediate; immSel  output  1  ALU operand 2 = immOut when 1, else register-file readData1.
REQ-012 writeEn  output  1  register-file write strobe.
REQ-013 psr  output  5  latched condition flags.
REQ-014 done  output  1  one-cycle pulse at instruction completion; illegal  output  1  qualifies done for an unsupported opcode.

Function
REQ-015 States SHALL be IDLE, DECODE, EXEC, WB; all outputs registered.
REQ-016 instrReady SHALL be 1 only in IDLE; handshake occurs when instrValid && instrReady on a rising edge; instruction latched, IDLE->DECODE.
REQ-017 instrValid outside IDLE SHALL be ignored; instrIn changes after acceptance SHALL have no effect.
REQ-018 DECODE SHALL drive dstAddr = instr[11:8], srcAddr = instr[3:0], aluOp, immSel, immOut; these hold through WB; DECODE->EXEC.
REQ-019 R-type (opcode 0000): aluOp = {instr[7:4], 4'b0000}, immSel = 0; opext in {0001,0010,0011,0101,0110,1001,1011} legal, else illegal.
REQ-020 Shift (opcode 1000): aluOp = {instr[7:4], 4'b0000} | 8'b1000_0000-class pass-through as {4'b1000, instr[7:4]}, immSel = 0; opext in {0000,0010,1000,0111} legal.
REQ-021 Immediate opcodes {0001,0010,0011,0101,0110,1001,1011}: aluOp = {opcode, 4'b0000}, immSel = 1.
REQ-022 immOut: logical opcodes (0001,0010,0011) zero-extend instr[7:0]; others sign-extend instr[7:0] (bit 7 replicated to bits 15:8).
REQ-023 Any other opcode/opext SHALL be illegal.
REQ-024 EXEC: psr <= aluConds at end of EXEC for legal instructions; psr unchanged for illegal; EXEC->WB.
REQ-025 WB: writeEn = 1 for exactly one cycle unless instruction is CMP/CMPI (ext/opcode 1011) or illegal (writeEn = 0); done = 1; illegal = 1 only for illegal; WB->IDLE.
REQ-026 Latency: handshake edge at cycle 0, writeEn/done in cycle 3, instrReady back high cycle 4; throughput one instruction per 4 cycles.
REQ-027 writeEn, done, illegal SHALL never be high outside WB.

Reset
REQ-028 reset low at a rising edge SHALL force IDLE, instrReady = 1, writeEn = 0, done = 0, illegal = 0, psr = 0, aluOp = 0, srcAddr = dstAddr = 0, immSel = 0, immOut = 0.
REQ-029 Reset in any state (incl. WB) SHALL abort the instruction with no further writeEn; reset dominates a simultaneous handshake.

Verification
REQ-030 ADD R3,R5 (0x0355) with aluConds = 0 -> aluOp 0x50, srcAddr 5, dstAddr 3, immSel 0, writeEn 1 in cycle 3 only, done 1, psr 00000.
REQ-031 ADDI R2,#-1 (0x52FF) -> aluOp 0x50, immSel 1, immOut 0xFFFF; ANDI R2,#0xFF (0x12FF) -> immOut 0x00FF.
REQ-032 CMP R1,R1 (0x01B1) with aluConds 00100 -> writeEn stays 0, done 1, psr 00100.
REQ-033 Illegal 0xF000 -> done and illegal 1 in cycle 3, writeEn 0, psr holds prior value.
REQ-034 Back-to-back: instrValid held high with two instructions -> second accepted exactly 4 cycles after first; instrReady 0 in cycles 1-3.
REQ-035 reset low during EXEC of ADD -> next cycle IDLE, all outputs at reset values, no writeEn pulse.
